// File: rtl/wib_pll_rst_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with timeout and retry,
// filters lock, then releases the output-domain reset after a hold-off.
//
// state     | meaning
// ----------|------------------------------------------------------------
// RESET_PLL | pll_rst asserted for RST_CYCLES cycles
// WAIT_LOCK | waiting up to LOCK_TIMEOUT cycles for synchronized lock
// FILTER    | lock must stay high for LOCK_FILTER consecutive cycles
// HOLD      | lock stable, holding sys_rst for DOMAIN_HOLD cycles
// RUN       | sys_rst released, pll_ready high until lock drops
module wib_pll_rst_ctrl #(
  parameter int RST_CYCLES   = 100,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_FILTER  = 1024,
  parameter int DOMAIN_HOLD  = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_FILTER > DOMAIN_HOLD) ? LOCK_FILTER : DOMAIN_HOLD;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FILTER_LOAD = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(DOMAIN_HOLD - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked_meta, locked_s;
  logic          retry_inc, lost_inc;

  // pll_locked is asynchronous to refclk; this pair is its only entry point
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? (cnt_q - CW'(1)) : cnt_q;
    retry_inc = 1'b0;
    lost_inc  = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_FILTER;
          cnt_d   = FILTER_LOAD;
        end else if (cnt_q == '0) begin
          state_d   = S_RESET_PLL;
          cnt_d     = RST_LOAD;
          retry_inc = 1'b1;
        end
      end
      S_FILTER: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = WAIT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = WAIT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d  = S_RESET_PLL;
          cnt_d    = RST_LOAD;
          lost_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = RST_LOAD;
      end
    endcase

    // software restart wins over everything, and is not counted as a fault
    if (force_relock) begin
      state_d   = S_RESET_PLL;
      cnt_d     = RST_LOAD;
      retry_inc = 1'b0;
      lost_inc  = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q       <= S_RESET_PLL;
      cnt_q         <= RST_LOAD;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      pll_ready     <= 1'b0;
      retry_cnt     <= 8'd0;
      lock_lost_cnt <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst   <= (state_d == S_RESET_PLL);
      sys_rst   <= (state_d != S_RUN);
      pll_ready <= (state_d == S_RUN);
      if (retry_inc && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
      if (lost_inc && (lock_lost_cnt != 8'hFF)) lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_wib_pll_rst_ctrl.sv
// Bench for wib_pll_rst_ctrl: directed test-plan scenarios plus random lock/force/reset
// traffic, every cycle compared against a duration-based behavioural model.
module tb_wib_pll_rst_ctrl;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int LF = 8;
  localparam int DH = 3;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst, pll_ready;
  logic [7:0] retry_cnt, lock_lost_cnt;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  // model: mode index, cycles spent in current mode, two-stage sync, counters
  int m_state = 0;
  int m_age = 0;
  bit m_s1 = 0, m_s2 = 0;
  int m_retry = 0, m_lost = 0;
  bit lk_v = 0;

  wib_pll_rst_ctrl #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_FILTER(LF), .DOMAIN_HOLD(DH)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .force_relock(force_relock),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .pll_ready(pll_ready),
    .retry_cnt(retry_cnt), .lock_lost_cnt(lock_lost_cnt), .state(state)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Each mode has a fixed dwell time; leaving it is decided by lock level and age.
  task automatic model_step(input bit rn, input bit lk, input bit fr);
    bit ls;
    int nxt;
    if (!rn) begin
      m_state = 0; m_age = 0; m_s1 = 0; m_s2 = 0; m_retry = 0; m_lost = 0;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      nxt = m_state;
      if (fr) nxt = 0;
      else begin
        case (m_state)
          0: if (m_age == RC - 1) nxt = 1;
          1: if (ls) nxt = 2;
             else if (m_age == LT - 1) begin nxt = 0; if (m_retry < 255) m_retry++; end
          2: if (!ls) nxt = 1; else if (m_age == LF - 1) nxt = 3;
          3: if (!ls) nxt = 1; else if (m_age == DH - 1) nxt = 4;
          default: if (!ls) begin nxt = 0; if (m_lost < 255) m_lost++; end
        endcase
      end
      m_age = (fr || nxt != m_state) ? 0 : m_age + 1;
      m_state = nxt;
    end
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("pll_rst", int'(pll_rst), (m_state == 0) ? 1 : 0);
    check("sys_rst", int'(sys_rst), (m_state != 4) ? 1 : 0);
    check("pll_ready", int'(pll_ready), (m_state == 4) ? 1 : 0);
    check("retry_cnt", int'(retry_cnt), m_retry);
    check("lock_lost_cnt", int'(lock_lost_cnt), m_lost);
  endtask

  task automatic step(input bit rn, input bit fr);
    rst_n = rn; pll_locked = lk_v; force_relock = fr;
    model_step(rn, lk_v, fr);
    @(negedge refclk);
    force_relock = 1'b0;
    compare_all();
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(state) != s && n < budget) begin step(1, 0); n++; end
    check("wait_state", int'(state), s);
  endtask

  // counts cycles pll_rst stays high, including the cycle already observed
  task automatic count_rst(output int n);
    n = 1;
    while (n < 40) begin
      step(1, 0);
      if (pll_rst) n++; else break;
    end
  endtask

  initial begin
    int n;
    int r0;

    // reset and clean bring-up
    lk_v = 0;
    step(0, 0);
    step(0, 0);
    count_rst(n);
    check("rst_pulse_len", n, RC);
    step(1, 0);
    lk_v = 1;
    wait_state(2, 20);
    n = 1;
    while (int'(state) == 2 && n < 40) begin step(1, 0); if (int'(state) == 2) n++; end
    check("filter_len", n, LF);
    n = 1;
    while (int'(state) == 3 && n < 40) begin step(1, 0); if (int'(state) == 3) n++; end
    check("hold_len", n, DH);
    check("run_ready", int'(pll_ready), 1);
    check("run_sys_rst", int'(sys_rst), 0);
    check("bringup_retry", int'(retry_cnt), 0);

    // force_relock in RUN, then extend the pulse from cycle 3
    step(1, 1);
    check("fr_run_state", int'(state), 0);
    check("fr_run_lost", int'(lock_lost_cnt), 0);
    step(1, 0);
    step(1, 0);
    step(1, 1);
    n = 4;
    while (n < 40) begin step(1, 0); if (pll_rst) n++; else break; end
    check("fr_extend_len", n, 3 + RC);

    // force_relock coinciding with a WAIT_LOCK timeout
    lk_v = 0;
    step(1, 1);
    wait_state(1, 20);
    repeat (LT - 1) step(1, 0);
    step(1, 1);
    check("fr_timeout_state", int'(state), 0);
    check("fr_timeout_retry", int'(retry_cnt), 0);

    // timeout/retry
    wait_state(1, 20);
    n = 1;
    while (int'(state) == 1 && n < 60) begin step(1, 0); if (int'(state) == 1) n++; end
    check("wait_len", n, LT);
    check("retry_one", int'(retry_cnt), 1);
    n = 0;
    while (int'(retry_cnt) != 3 && n < 200) begin step(1, 0); n++; end
    check("retry_three", int'(retry_cnt), 3);
    lk_v = 1;
    wait_state(4, 80);

    // lock glitch at FILTER cycle 5
    step(1, 1);
    wait_state(2, 40);
    repeat (3) step(1, 0);
    lk_v = 0;
    step(1, 0);
    lk_v = 1;
    wait_state(1, 10);
    wait_state(2, 10);
    n = 1;
    while (int'(state) == 2 && n < 40) begin step(1, 0); if (int'(state) == 2) n++; end
    check("refilter_len", n, LF);
    check("glitch_retry", int'(retry_cnt), 3);

    // reset mid-HOLD
    wait_state(3, 10);
    step(0, 1);
    check("midhold_state", int'(state), 0);
    check("midhold_retry", int'(retry_cnt), 0);
    count_rst(n);
    check("midhold_pulse", n, RC);
    wait_state(4, 60);

    // lock loss in RUN, repeated to saturation
    for (int i = 0; i < 300; i++) begin
      lk_v = 0;
      n = 0;
      while (n < 10) begin step(1, 0); n++; if (pll_rst) break; end
      if (i == 0) begin
        check("loss_latency", n, 3);
        check("loss_count", int'(lock_lost_cnt), 1);
      end
      lk_v = 1;
      wait_state(4, 60);
    end
    check("lost_saturated", int'(lock_lost_cnt), 255);

    // random traffic
    r0 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) lk_v = ~lk_v;
      if ($urandom_range(0, 599) == 0) begin step(0, $urandom_range(0, 1)); r0++; end
      else step(1, ($urandom_range(0, 119) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
